// File: rtl/logic16_pkg.sv
// Shared definitions for the 16-bit logic-unit arbiter slice.
// Holds the datapath width, the op encodings and the 16-bit gate
// primitives that the logic unit is built from.
package logic16_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    // 16-bit AND gate
    function automatic logic [DATA_W-1:0] and16(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return a & b;
    endfunction

    // 16-bit OR gate
    function automatic logic [DATA_W-1:0] or16(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return a | b;
    endfunction

    // 16-bit inverter
    function automatic logic [DATA_W-1:0] not16(input logic [DATA_W-1:0] a);
        return ~a;
    endfunction

endpackage

// File: rtl/logic16_unit.sv
// Combinational 16-bit bitwise logic unit.
// Ports:
//   a, b : operands (b unused for NOT)
//   op   : 00 AND, 01 OR, 10 XOR, 11 NOT a
//   y    : result
module logic16_unit
    import logic16_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] and_s;
    logic [DATA_W-1:0] or_s;
    logic [DATA_W-1:0] nota_s;
    logic [DATA_W-1:0] xor_s;

    assign and_s  = and16(a, b);
    assign or_s   = or16(a, b);
    assign nota_s = not16(a);
    // XOR from the available gates: (a|b) & ~(a&b)
    assign xor_s  = and16(or_s, not16(and_s));

    // 4:1 result select on the op code
    always_comb begin
        y = {DATA_W{1'b0}};
        case (op)
            OP_AND:  y = and_s;
            OP_OR:   y = or_s;
            OP_XOR:  y = xor_s;
            OP_NOT:  y = nota_s;
            default: y = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/logic16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit logic unit among N requesters.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : per-requester handshake (at most one ready bit high)
//   req_op/a/b        : packed per-requester op (2b) and operands (16b each)
//   rsp_valid/ready   : registered result handshake
//   rsp_data, rsp_id  : result and index of the requester that issued it
//   ops_done          : count of consumed results, wraps at 2^16
// The output register is a one-entry buffer; rsp_valid is its FULL flag.
module logic16_rr_arbiter
    import logic16_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [2*N-1:0]    req_op,
    input  logic [16*N-1:0]   req_a,
    input  logic [16*N-1:0]   req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       ops_done
);

    logic [IDW-1:0]    ptr_r;
    logic              slot_free_s;
    logic              grant_found_s;
    logic [IDW-1:0]    grant_id_s;
    logic [IDW-1:0]    ptr_next_s;
    logic              accept_s;
    logic [1:0]        op_arr_s [N];
    logic [DATA_W-1:0] a_arr_s  [N];
    logic [DATA_W-1:0] b_arr_s  [N];
    logic [DATA_W-1:0] unit_y_s;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_unpack
            assign op_arr_s[g] = req_op[2*g +: 2];
            assign a_arr_s[g]  = req_a[16*g +: 16];
            assign b_arr_s[g]  = req_b[16*g +: 16];
        end
    endgenerate

    // Slot can take a new result when empty or being drained this cycle
    assign slot_free_s = !rsp_valid || rsp_ready;

    // Rotating priority search: scan from the highest offset down so the
    // last hit is the first valid requester at or after ptr_r
    always_comb begin
        logic [IDW:0] sum_v;
        grant_found_s = 1'b0;
        grant_id_s    = {IDW{1'b0}};
        sum_v         = {(IDW+1){1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            sum_v = {1'b0, ptr_r} + (IDW+1)'(k);
            if (sum_v >= (IDW+1)'(N)) begin
                sum_v = sum_v - (IDW+1)'(N);
            end else begin
                sum_v = sum_v;
            end
            if (req_valid[sum_v[IDW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = sum_v[IDW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Handshake happens only out of reset, with a free slot and a winner
    assign accept_s = rst_n && slot_free_s && grant_found_s;

    // One-hot ready toward the winning requester
    always_comb begin
        req_ready = {N{1'b0}};
        if (accept_s) begin
            req_ready[grant_id_s] = 1'b1;
        end else begin
            req_ready = {N{1'b0}};
        end
    end

    // Pointer moves to the requester after the winner, wrapping at N
    always_comb begin
        ptr_next_s = {IDW{1'b0}};
        if (grant_id_s == IDW'(N - 1)) begin
            ptr_next_s = {IDW{1'b0}};
        end else begin
            ptr_next_s = grant_id_s + IDW'(1);
        end
    end

    logic16_unit u_unit (
        .a  (a_arr_s[grant_id_s]),
        .b  (b_arr_s[grant_id_s]),
        .op (op_arr_s[grant_id_s]),
        .y  (unit_y_s)
    );

    // Output buffer and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_id    <= {IDW{1'b0}};
            ptr_r     <= {IDW{1'b0}};
        end else if (accept_s) begin
            rsp_valid <= 1'b1;
            rsp_data  <= unit_y_s;
            rsp_id    <= grant_id_s;
            ptr_r     <= ptr_next_s;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid;
        end
    end

    // Completed-response counter, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= 16'h0000;
        end else if (rsp_valid && rsp_ready) begin
            ops_done <= ops_done + 16'd1;
        end else begin
            ops_done <= ops_done;
        end
    end

endmodule

// File: tb/tb_logic16_rr_arbiter.sv
// Self-checking bench for logic16_rr_arbiter (N=4).
// A reference model tracks pointer, slot and counter at every falling edge;
// accepted requests push expected results onto a queue that is compared
// when the DUT presents them. Table vectors and directed sequences cover
// the op decode, fairness, backpressure, pointer skip, reset and wrap.
module tb_logic16_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] ops_done;

    int total_r = 0;
    int bad_r   = 0;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  id;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[6];

    // model state
    logic [1:0]  m_ptr_r   = 2'd0;
    logic        m_valid_r = 1'b0;
    logic [15:0] m_ops_r   = 16'h0000;
    logic        chk_pending_r = 1'b0;

    logic16_rr_arbiter #(.N(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .ops_done  (ops_done)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_r++;
        if (act !== exp) begin
            bad_r++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        req_op[2*i +: 2]  = op;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    // Reference model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        logic       slot_free_v;
        logic       found_v;
        logic [1:0] gid_v;
        logic [1:0] idx_v;
        logic [3:0] exp_ready_v;
        exp_t       e_v;
        if (!rst_n) begin
            check("rst_req_ready", {28'd0, req_ready}, 32'd0);
            check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
            check("rst_ops_done", {16'd0, ops_done}, 32'd0);
            m_ptr_r       = 2'd0;
            m_valid_r     = 1'b0;
            m_ops_r       = 16'h0000;
            chk_pending_r = 1'b0;
            sb_q.delete();
        end else begin
            if (chk_pending_r) begin
                chk_pending_r = 1'b0;
                check("rsp_valid_after_accept", {31'd0, rsp_valid}, 32'd1);
                if (sb_q.size() > 0) begin
                    check("sb_data", {16'd0, rsp_data}, {16'd0, sb_q[0].data});
                    check("sb_id", {30'd0, rsp_id}, {30'd0, sb_q[0].id});
                end
            end
            check("model_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid_r});
            check("model_ops_done", {16'd0, ops_done}, {16'd0, m_ops_r});
            slot_free_v = !m_valid_r || rsp_ready;
            found_v = 1'b0;
            gid_v   = 2'd0;
            for (int k = 0; k < 4; k++) begin
                idx_v = m_ptr_r + 2'(k);
                if (!found_v && req_valid[idx_v]) begin
                    found_v = 1'b1;
                    gid_v   = idx_v;
                end
            end
            exp_ready_v = 4'b0000;
            if (slot_free_v && found_v) exp_ready_v[gid_v] = 1'b1;
            check("model_req_ready", {28'd0, req_ready}, {28'd0, exp_ready_v});
            if (m_valid_r && rsp_ready) begin
                check("sb_nonempty_on_pop", sb_q.size(), 32'd1);
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                m_ops_r   = m_ops_r + 16'd1;
                m_valid_r = 1'b0;
            end
            if (slot_free_v && found_v) begin
                e_v.data = ref_op(req_op[2*gid_v +: 2], req_a[16*gid_v +: 16], req_b[16*gid_v +: 16]);
                e_v.id   = gid_v;
                sb_q.push_back(e_v);
                m_valid_r     = 1'b1;
                m_ptr_r       = gid_v + 2'd1;
                chk_pending_r = 1'b1;
            end
        end
    end

    initial begin
        logic [1:0] fair_ids[6];
        vecs[0] = '{op: 2'b00, a: 16'hF0F0, b: 16'hFF00, exp: 16'hF000};
        vecs[1] = '{op: 2'b01, a: 16'hF0F0, b: 16'hFF00, exp: 16'hFFF0};
        vecs[2] = '{op: 2'b10, a: 16'hF0F0, b: 16'hFF00, exp: 16'h0FF0};
        vecs[3] = '{op: 2'b11, a: 16'hF0F0, b: 16'hFF00, exp: 16'h0F0F};
        vecs[4] = '{op: 2'b00, a: 16'h1234, b: 16'h00FF, exp: 16'h0034};
        vecs[5] = '{op: 2'b01, a: 16'hAAAA, b: 16'h5555, exp: 16'hFFFF};
        fair_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // 1. reset with all requesters valid
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_op    = 8'h00;
        req_a     = 64'h0;
        req_b     = 64'h0;
        #12;
        check("t1_req_ready", {28'd0, req_ready}, 32'd0);
        check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t1_ops_done", {16'd0, ops_done}, 32'd0);
        step();
        req_valid = 4'b0000;
        rst_n     = 1'b1;

        // 2. op table on requester 0
        for (int v = 0; v < 6; v++) begin
            set_req(0, vecs[v].op, vecs[v].a, vecs[v].b);
            req_valid = 4'b0001;
            step();
            check("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("t2_rsp_data", {16'd0, rsp_data}, {16'd0, vecs[v].exp});
            check("t2_rsp_id", {30'd0, rsp_id}, 32'd0);
        end
        req_valid = 4'b0000;

        // 3. fairness with all requesters valid
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 2'(i), 16'h1111 * 16'(i + 1), 16'h0F0F);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("t3_rsp_id", {30'd0, rsp_id}, {30'd0, fair_ids[k]});
        end
        req_valid = 4'b0000;
        step();
        check("t3_ops_done", {16'd0, ops_done}, 32'd6);

        // 4. backpressure holds result and blocks grants
        apply_reset();
        rsp_ready = 1'b0;
        set_req(1, 2'b01, 16'h1234, 16'h0000);
        set_req(2, 2'b10, 16'h00FF, 16'h0F0F);
        req_valid = 4'b0110;
        step();
        check("t4_first_id", {30'd0, rsp_id}, 32'd1);
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_hold_data", {16'd0, rsp_data}, 32'h1234);
            check("t4_hold_ready", {28'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_release_ready", {28'd0, req_ready}, 32'b0100);
        step();
        check("t4_next_data", {16'd0, rsp_data}, 32'h0FF0);
        check("t4_next_id", {30'd0, rsp_id}, 32'd2);
        req_valid = 4'b0000;

        // 5. pointer skip
        apply_reset();
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1000;
        #1;
        check("t5_skip_to_3", {28'd0, req_ready}, 32'b1000);
        step();
        req_valid = 4'b1001;
        #1;
        check("t5_wrap_to_0", {28'd0, req_ready}, 32'b0001);
        step();
        req_valid = 4'b0000;
        step();

        // 6a. reset while a result is pending
        req_valid = 4'b0001;
        step();
        check("t6_pending_before", {31'd0, rsp_valid}, 32'd1);
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        #1;
        check("t6_async_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_after_valid", {31'd0, rsp_valid}, 32'd0);
        check("t6_after_ops", {16'd0, ops_done}, 32'd0);

        // 6b. counter wrap: one completion per cycle from requester 0
        set_req(0, 2'b11, 16'h00FF, 16'h0000);
        req_valid = 4'b0001;
        for (int k = 0; k < 65536; k++) begin
            step();
        end
        check("t6_ops_ffff", {16'd0, ops_done}, 32'h0000FFFF);
        step();
        check("t6_ops_wrap", {16'd0, ops_done}, 32'd0);
        req_valid = 4'b0000;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule
